// File: rtl/tlight_pkg.sv
// Shared lamp encodings, monitor state/pattern types and default phase timings
// used by the traffic-light controller, the monitor and their benches.
package tlight_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int YELLOW_CYCLES_DEF    = 3;
    localparam int RED_GREEN_CYCLES_DEF = 15;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        YYU  = 3'd1,
        YY1  = 3'd2,
        RG   = 3'd3,
        YY2  = 3'd4,
        GR   = 3'd5
    } tlm_state_t;

    // Pattern labels carry a prefix so they do not collide with the state names.
    typedef enum logic [1:0] {
        PAT_ILL = 2'd0,
        PAT_YY  = 2'd1,
        PAT_RG  = 2'd2,
        PAT_GR  = 2'd3
    } tlm_pat_t;

    function automatic tlm_pat_t state_pat(tlm_state_t s);
        case (s)
            YYU, YY1, YY2: return PAT_YY;
            RG:            return PAT_RG;
            GR:            return PAT_GR;
            default:       return PAT_ILL;
        endcase
    endfunction

    function automatic tlm_state_t pat_entry(tlm_pat_t p);
        case (p)
            PAT_YY:  return YYU;
            PAT_RG:  return RG;
            PAT_GR:  return GR;
            default: return SYNC;
        endcase
    endfunction

endpackage

// File: rtl/tlight_pat_decode.sv
// Combinational lamp-pattern decoder: ns/we lamp buses -> tlm_pat_t.
module tlight_pat_decode
    import tlight_pkg::*;
(
    input  logic [2:0] ns,
    input  logic [2:0] we,
    output tlm_pat_t   pat
);

    always_comb begin
        pat = PAT_ILL;
        if (ns == YELLOW && we == YELLOW) pat = PAT_YY;
        else if (ns == RED && we == GREEN) pat = PAT_RG;
        else if (ns == GREEN && we == RED) pat = PAT_GR;
    end

endmodule

// File: rtl/tlight_monitor.sv
// Traffic-light lamp monitor: phase sequence/timing checker and rotation counter.
// Optional err_count output is enabled with `define TLIGHT_MON_ERRCNT_EN.
module tlight_monitor
    import tlight_pkg::*;
#(
    parameter int YELLOW_CYCLES    = YELLOW_CYCLES_DEF,
    parameter int RED_GREEN_CYCLES = RED_GREEN_CYCLES_DEF,
    parameter int ROT_W            = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       ns,
    input  logic [2:0]       we,
    input  logic             clear,
    output logic [2:0]       phase,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_time,
    output logic             err_any,
    output logic [ROT_W-1:0] rot_count
`ifdef TLIGHT_MON_ERRCNT_EN
   ,output logic [7:0]       err_count
`endif
);

    localparam int DW = $clog2(RED_GREEN_CYCLES + 2);
    localparam logic [DW-1:0] DMAX = '1;
    localparam logic [DW-1:0] YC   = DW'(YELLOW_CYCLES);
    localparam logic [DW-1:0] RGC  = DW'(RED_GREEN_CYCLES);

    tlm_pat_t   pat;
    tlm_state_t state, st_n, succ;
    logic [DW-1:0] dur, dur_n, req;
    logic first, first_n, succ_ok;
    logic ill_n, seq_n, tim_n, rot_inc, any_n;

    tlight_pat_decode u_dec (.ns(ns), .we(we), .pat(pat));

    always_comb begin
        succ    = SYNC;
        succ_ok = 1'b0;
        case (state)
            YYU: if (pat == PAT_RG || pat == PAT_GR) begin succ = pat_entry(pat); succ_ok = 1'b1; end
            YY1: if (pat == PAT_RG) begin succ = RG;  succ_ok = 1'b1; end
            RG:  if (pat == PAT_YY) begin succ = YY2; succ_ok = 1'b1; end
            YY2: if (pat == PAT_GR) begin succ = GR;  succ_ok = 1'b1; end
            GR:  if (pat == PAT_YY) begin succ = YY1; succ_ok = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        st_n    = state;
        dur_n   = dur;
        first_n = first;
        ill_n   = 1'b0;
        seq_n   = 1'b0;
        tim_n   = 1'b0;
        rot_inc = 1'b0;
        req     = (state_pat(state) == PAT_YY) ? YC : RGC;
        if (pat == PAT_ILL) begin
            ill_n = 1'b1;
            st_n  = SYNC;
            dur_n = '0;
        end else if (state == SYNC) begin
            st_n    = pat_entry(pat);
            dur_n   = DW'(1);
            first_n = 1'b1;
        end else if (pat == state_pat(state)) begin
            if (dur != DMAX) dur_n = dur + 1'b1;
            tim_n = !first && (dur == req);
        end else if (succ_ok) begin
            // Over-long phases were already flagged while running, so only a short one fires here.
            tim_n   = !first && (dur < req);
            rot_inc = !first && (state == GR);
            st_n    = succ;
            dur_n   = DW'(1);
            first_n = 1'b0;
        end else begin
            seq_n   = 1'b1;
            st_n    = pat_entry(pat);
            dur_n   = DW'(1);
            first_n = 1'b1;
        end
        any_n = ill_n | seq_n | tim_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SYNC;
            dur         <= '0;
            first       <= 1'b1;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_time    <= 1'b0;
            err_any     <= 1'b0;
            rot_count   <= '0;
        end else begin
            state       <= st_n;
            dur         <= dur_n;
            first       <= first_n;
            err_illegal <= ill_n;
            err_seq     <= seq_n;
            err_time    <= tim_n;
            err_any     <= (err_any & ~clear) | any_n;
            if (clear) rot_count <= '0;
            else if (rot_inc && rot_count != '1) rot_count <= rot_count + 1'b1;
        end
    end

`ifdef TLIGHT_MON_ERRCNT_EN
    always_ff @(posedge clock) begin
        if (reset) err_count <= '0;
        else if (clear) err_count <= {7'd0, any_n};
        else if (any_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif

    assign phase = state;

endmodule

// File: tb/tb_tlight_monitor.sv
// Directed bench for tlight_monitor with a pattern-history reference model.
module tb_tlight_monitor;

    localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;
    localparam int YC = 3, RGC = 15;

    logic clock = 0, reset = 1, clear = 0;
    logic [2:0] ns = LY, we = LY;
    logic [2:0] phase;
    logic err_illegal, err_seq, err_time, err_any;
    logic [7:0] rot_count;
`ifdef TLIGHT_MON_ERRCNT_EN
    logic [7:0] err_count;
`endif

    tlight_monitor dut (
        .clock(clock), .reset(reset), .ns(ns), .we(we), .clear(clear),
        .phase(phase), .err_illegal(err_illegal), .err_seq(err_seq),
        .err_time(err_time), .err_any(err_any), .rot_count(rot_count)
`ifdef TLIGHT_MON_ERRCNT_EN
       ,.err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    int nvec = 0, nbad = 0;
    int cnt_tim = 0, cnt_seq = 0, cnt_ill = 0;

    // Model: rotation is the pattern list YY,RG,YY,GR; pos -1 means "yellow, position unknown".
    int rotpat [4] = '{1, 2, 1, 3};
    int m_sync, m_pat, m_len, m_meas, m_pos, m_rot, m_any, m_cnt, m_phase;
    int e_ill, e_seq, e_tim;

    function automatic int dec(logic [2:0] n, logic [2:0] w);
        if (n == LY && w == LY) return 1;
        if (n == LR && w == LG) return 2;
        if (n == LG && w == LR) return 3;
        return 0;
    endfunction

    function automatic int pos_of(int p);
        return (p == 1) ? -1 : (p == 2) ? 1 : 3;
    endfunction

    function automatic int req(int pos);
        return (pos == 1 || pos == 3) ? RGC : YC;
    endfunction

    task automatic model();
        int p, np, e;
        e_ill = 0; e_seq = 0; e_tim = 0;
        if (reset) begin
            m_sync = 0; m_len = 0; m_meas = 0; m_pos = -1; m_pat = 0;
            m_rot = 0; m_any = 0; m_cnt = 0; m_phase = 0;
            return;
        end
        p = dec(ns, we);
        if (p == 0) begin
            e_ill = 1; m_sync = 0; m_len = 0;
        end else if (m_sync == 0) begin
            m_sync = 1; m_pat = p; m_len = 1; m_meas = 0; m_pos = pos_of(p);
        end else if (p == m_pat) begin
            if (m_len < 31) m_len++;
            if (m_meas != 0 && m_len == req(m_pos) + 1) e_tim = 1;
        end else begin
            np = -2;
            if (m_pos == -1) np = (p != 1) ? pos_of(p) : -2;
            else if (rotpat[(m_pos + 1) % 4] == p) np = (m_pos + 1) % 4;
            if (np != -2) begin
                if (m_meas != 0 && m_len < req(m_pos)) e_tim = 1;
                if (m_meas != 0 && m_pos == 3 && m_rot < 255) m_rot++;
                m_pos = np; m_meas = 1;
            end else begin
                e_seq = 1; m_pos = pos_of(p); m_meas = 0;
            end
            m_pat = p; m_len = 1;
        end
        e = e_ill | e_seq | e_tim;
        if (clear) begin
            m_any = e; m_rot = 0; m_cnt = e;
        end else begin
            m_any = m_any | e;
            if (e != 0 && m_cnt < 255) m_cnt++;
        end
        m_phase = (m_sync != 0) ? m_pos + 2 : 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] n, input logic [2:0] w, input logic c);
        bit bad;
        ns = n; we = w; clear = c;
        @(posedge clock);
        model();
        @(negedge clock);
        bad = (phase != 3'(m_phase)) || (err_illegal != e_ill[0]) || (err_seq != e_seq[0]) ||
              (err_time != e_tim[0]) || (err_any != m_any[0]) || (rot_count != 8'(m_rot));
`ifdef TLIGHT_MON_ERRCNT_EN
        bad = bad || (err_count != 8'(m_cnt));
`endif
        nvec++;
        if (bad) begin
            nbad++;
            $display("FAIL cycle t=%0t: got ph=%0d ill=%0b seq=%0b tim=%0b any=%0b rot=%0d expected ph=%0d ill=%0d seq=%0d tim=%0d any=%0d rot=%0d",
                     $time, phase, err_illegal, err_seq, err_time, err_any, rot_count,
                     m_phase, e_ill, e_seq, e_tim, m_any, m_rot);
        end
        cnt_tim += int'(err_time);
        cnt_seq += int'(err_seq);
        cnt_ill += int'(err_illegal);
    endtask

    task automatic run(input logic [2:0] n, input logic [2:0] w, input int k);
        for (int i = 0; i < k; i++) step(n, w, 1'b0);
    endtask

    task automatic rotation();
        run(LY, LY, YC); run(LR, LG, RGC); run(LY, LY, YC); run(LG, LR, RGC);
    endtask

    initial begin
        reset = 1;
        step(LY, LY, 0); step(LY, LY, 0);
        chk("reset phase", phase, 0);
        chk("reset err_any", err_any, 0);
        chk("reset rot", rot_count, 0);
        reset = 0;

        for (int r = 0; r < 3; r++) rotation();
        run(LY, LY, YC);
        chk("clean rot", rot_count, 3);
        chk("clean errs", cnt_tim + cnt_seq + cnt_ill, 0);
        chk("clean phase YY1", phase, 2);

        run(LR, LG, RGC - 1);
        step(LY, LY, 0);
        chk("short RG err_time", err_time, 1);
        run(LY, LY, YC - 1);
        chk("short RG one pulse", cnt_tim, 1);
        chk("short err_any", err_any, 1);
        run(LG, LR, RGC); run(LY, LY, YC);
        chk("rot after short", rot_count, 4);

        run(LR, LG, RGC); run(LY, LY, YC);
        run(LG, LR, RGC);
        step(LG, LR, 0);
        chk("long GR pulse", err_time, 1);
        step(LG, LR, 0);
        chk("long GR no repeat", err_time, 0);
        run(LY, LY, YC);
        chk("long GR one pulse", cnt_tim, 2);
        chk("rot after long", rot_count, 5);

        run(LR, LG, RGC);
        step(LG, LR, 0);
        chk("RG->GR err_seq", err_seq, 1);
        chk("RG->GR phase", phase, 5);
        run(LG, LR, 4); run(LY, LY, YC);
        chk("partial GR unchecked", cnt_tim, 2);
        chk("no rot after seq", rot_count, 5);
        rotation(); run(LY, LY, YC);
        chk("rot resumes", rot_count, 6);

        run(LG, LG, 2);
        chk("both green ill", cnt_ill, 2);
        chk("ill phase SYNC", phase, 0);
        run(LY, LY, YC);
        chk("resync YYU", phase, 1);
        chk("resync no seq", cnt_seq, 1);
        step(3'b110, LR, 0);
        chk("non-onehot ill", err_illegal, 1);
        run(LY, LY, 2); run(LR, LG, 4);
        step(LG, LR, 1);
        chk("clear+err err_any", err_any, 1);
        chk("clear+err rot", rot_count, 0);
`ifdef TLIGHT_MON_ERRCNT_EN
        chk("clear+err err_count", err_count, 1);
`endif
        step(LG, LR, 1);
        chk("quiet clear err_any", err_any, 0);
        run(LG, LR, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
